// File: rtl/nonce_sched.sv
// nonce_sched: issues a nonce range into the Blake2b pipeline, latches the first winner, drains and reports.
module nonce_sched #(
  parameter int INFL_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] start_nonce,
  input  logic [31:0] nonce_count,
  input  logic        hash_ready,
  output logic        hash_valid,
  output logic [31:0] hash_nonce,
  input  logic        cmp_busy,
  input  logic        cmp_found,
  input  logic [31:0] cmp_nonce,
  output logic        busy,
  output logic        done,
  output logic        result_found,
  output logic        result_aborted,
  output logic [31:0] result_nonce,
  output logic [31:0] hash_count
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [31:0] next_nonce, remaining;
  logic [INFL_W-1:0] inflight;
  logic dec, cap, run_abort;
  always_comb begin
    run_abort = state == RUN && abort;
    hash_valid = state == RUN && hash_ready && !abort && remaining != 0 && inflight != '1;
    hash_nonce = next_nonce;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    // results with nothing outstanding are protocol errors: counted but never decrement or capture
    dec = busy && cmp_busy && inflight != '0;
    cap = dec && cmp_found && !result_found && !result_aborted && !run_abort;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      next_nonce <= '0;
      remaining <= '0;
      inflight <= '0;
      result_found <= 1'b0;
      result_aborted <= 1'b0;
      result_nonce <= '0;
      hash_count <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      next_nonce <= start_nonce;
      remaining <= nonce_count;
      inflight <= '0;
      result_found <= 1'b0;
      result_aborted <= 1'b0;
      result_nonce <= '0;
      hash_count <= '0;
      state <= nonce_count == 0 ? DRAIN : RUN;
    end else begin
      if (hash_valid) begin
        next_nonce <= next_nonce + 32'd1;
        remaining <= remaining - 32'd1;
      end
      inflight <= inflight + INFL_W'(hash_valid) - INFL_W'(dec);
      if (busy && cmp_busy) hash_count <= hash_count + 32'd1;
      if (cap) begin
        result_found <= 1'b1;
        result_nonce <= cmp_nonce;
      end
      if (run_abort) result_aborted <= 1'b1;
      if (state == RUN && (abort || cap || (hash_valid && remaining == 32'd1))) state <= DRAIN;
      else if (state == DRAIN && inflight == '0 && !cmp_busy) state <= DONE;
    end
  end
endmodule

// File: tb/tb_nonce_sched.sv
// tb_nonce_sched: directed scenarios against a 3-cycle comparator model.
module tb_nonce_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, hash_ready = 1'b0;
  logic [31:0] start_nonce = '0, nonce_count = '0;
  logic hash_valid, busy, done, result_found, result_aborted;
  logic [31:0] hash_nonce, result_nonce, hash_count;
  logic cmp_busy, cmp_found;
  logic [31:0] cmp_nonce;
  logic [31:0] win_a = 32'hDEAD0000, win_b = 32'hDEAD0000;
  logic [2:0] pv = '0;
  logic [31:0] pn [3];
  logic [31:0] log_mem [4096];
  int nlog = 0;
  int pass = 0, total = 0;

  nonce_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_nonce(start_nonce), .nonce_count(nonce_count),
    .hash_ready(hash_ready), .hash_valid(hash_valid), .hash_nonce(hash_nonce),
    .cmp_busy(cmp_busy), .cmp_found(cmp_found), .cmp_nonce(cmp_nonce),
    .busy(busy), .done(done), .result_found(result_found),
    .result_aborted(result_aborted), .result_nonce(result_nonce), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv <= {pv[1:0], hash_valid};
    pn[0] <= hash_nonce;
    pn[1] <= pn[0];
    pn[2] <= pn[1];
    if (hash_valid) begin
      log_mem[nlog % 4096] <= hash_nonce;
      nlog <= nlog + 1;
    end
  end
  assign cmp_busy = pv[2];
  assign cmp_nonce = pn[2];
  assign cmp_found = pv[2] && (pn[2] == win_a || pn[2] == win_b);

  task automatic do_start(input logic [31:0] sn, input logic [31:0] cnt);
    @(negedge clk);
    start = 1'b1; start_nonce = sn; nonce_count = cnt;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (done !== 1'b1) $display("FAIL %s_done_timeout got done=%0b want 1", name, done);
    else pass++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    total++;
    if ({hash_valid, busy, done, result_found, result_aborted} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {hash_valid, busy, done, result_found, result_aborted});
    else pass++;
    total++;
    if ({result_nonce, hash_count} !== 64'h0) $display("FAIL reset_values got %h want 0", {result_nonce, hash_count});
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaust;
    hash_ready = 1'b1;
    do_start(32'h100, 32'd4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (hash_valid !== 1'b1 || hash_nonce !== 32'h100 + i) $display("FAIL exhaust_issue%0d got v=%0b n=%h want v=1 n=%h", i, hash_valid, hash_nonce, 32'h100 + i);
      else pass++;
      @(negedge clk);
      #1;
    end
    total++;
    if (hash_valid !== 1'b0 || busy !== 1'b1) $display("FAIL exhaust_stop got v=%0b busy=%0b want v=0 busy=1", hash_valid, busy);
    else pass++;
    wait_done("exhaust");
    total++;
    if (result_found !== 1'b0 || result_aborted !== 1'b0 || hash_count !== 32'd4 || busy !== 1'b0) $display("FAIL exhaust_result got f=%0b a=%0b cnt=%0d busy=%0b want 0 0 4 0", result_found, result_aborted, hash_count, busy);
    else pass++;
  endtask

  task automatic test_hit;
    int base;
    win_a = 32'h105;
    base = nlog;
    do_start(32'h100, 32'd16);
    wait_done("hit");
    total++;
    if (nlog - base !== 9) $display("FAIL hit_issued got %0d want 9", nlog - base);
    else pass++;
    total++;
    if (result_found !== 1'b1 || result_nonce !== 32'h105 || hash_count !== 32'd9 || result_aborted !== 1'b0) $display("FAIL hit_result got f=%0b n=%h cnt=%0d a=%0b want 1 105 9 0", result_found, result_nonce, hash_count, result_aborted);
    else pass++;
    win_a = 32'hDEAD0000;
  endtask

  task automatic test_wrap_backpressure;
    logic [31:0] exp_n = 32'hFFFFFFFE;
    int issued = 0;
    hash_ready = 1'b1;
    do_start(32'hFFFFFFFE, 32'd4);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        hash_ready = (i % 2 == 0);
        #1;
      end
      total++;
      if (hash_valid !== hash_ready || (hash_ready && hash_nonce !== exp_n)) $display("FAIL wrap_cycle%0d got v=%0b n=%h want v=%0b n=%h", i, hash_valid, hash_nonce, hash_ready, exp_n);
      else pass++;
      if (hash_ready) begin
        exp_n = exp_n + 32'd1;
        issued++;
      end
    end
    hash_ready = 1'b1;
    wait_done("wrap");
    total++;
    if (hash_count !== 32'd4 || issued != 4 || log_mem[(nlog - 1) % 4096] !== 32'h1) $display("FAIL wrap_result got cnt=%0d last=%h want 4 00000001", hash_count, log_mem[(nlog - 1) % 4096]);
    else pass++;
  endtask

  task automatic test_abort;
    int base;
    win_a = 32'h206;
    base = nlog;
    do_start(32'h200, 32'd1000);
    for (int i = 0; i < 9; i++) @(negedge clk);
    abort = 1'b1;
    #1;
    total++;
    if (hash_valid !== 1'b0 || cmp_found !== 1'b1) $display("FAIL abort_suppress got v=%0b found_in=%0b want 0 1", hash_valid, cmp_found);
    else pass++;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    total++;
    if (nlog - base !== 9) $display("FAIL abort_issued got %0d want 9", nlog - base);
    else pass++;
    total++;
    if (result_aborted !== 1'b1 || result_found !== 1'b0 || hash_count !== 32'd9) $display("FAIL abort_result got a=%0b f=%0b cnt=%0d want 1 0 9", result_aborted, result_found, hash_count);
    else pass++;
    win_a = 32'hDEAD0000;
  endtask

  task automatic test_double_winner;
    win_a = 32'h302;
    win_b = 32'h303;
    do_start(32'h300, 32'd8);
    wait_done("double");
    total++;
    if (result_found !== 1'b1 || result_nonce !== 32'h302 || hash_count !== 32'd6) $display("FAIL double_result got f=%0b n=%h cnt=%0d want 1 302 6", result_found, result_nonce, hash_count);
    else pass++;
    win_a = 32'hDEAD0000;
    win_b = 32'hDEAD0000;
  endtask

  task automatic test_empty;
    do_start(32'h500, 32'd0);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || hash_valid !== 1'b0 || result_found !== 1'b0) $display("FAIL empty_drain got done=%0b busy=%0b v=%0b f=%0b want 0 1 0 0", done, busy, hash_valid, result_found);
    else pass++;
    @(negedge clk);
    #1;
    total++;
    if (done !== 1'b1 || hash_count !== 32'd0) $display("FAIL empty_done got done=%0b cnt=%0d want 1 0", done, hash_count);
    else pass++;
  endtask

  task automatic test_reset_mid_job;
    int base;
    do_start(32'h600, 32'd20);
    for (int i = 0; i < 21; i++) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || hash_valid !== 1'b0 || done !== 1'b0) $display("FAIL midreset_drain got busy=%0b v=%0b done=%0b want 1 0 0", busy, hash_valid, done);
    else pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({hash_valid, busy, done, result_found, result_aborted} !== 5'b0 || {result_nonce, hash_count} !== 64'h0) $display("FAIL midreset_outputs got flags=%b nonce=%h cnt=%0d want 0", {hash_valid, busy, done, result_found, result_aborted}, result_nonce, hash_count);
    else pass++;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b1;
    base = nlog;
    do_start(32'h700, 32'd2);
    wait_done("fresh");
    total++;
    if (nlog - base !== 2 || log_mem[base % 4096] !== 32'h700 || log_mem[(base + 1) % 4096] !== 32'h701 || hash_count !== 32'd2) $display("FAIL fresh_job got issued=%0d first=%h cnt=%0d want 2 700 2", nlog - base, log_mem[base % 4096], hash_count);
    else pass++;
  endtask

  initial begin
    test_reset;
    test_exhaust;
    test_hit;
    test_wrap_backpressure;
    test_abort;
    test_double_winner;
    test_empty;
    test_reset_mid_job;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
